// File: rtl/sm_ctrl_pkg.sv
// rtl/sm_ctrl_pkg.sv - shared types and constants for the SPM configuration sequencer
// Contents:
//   ADDR_W      address width of the text/data range registers
//   state_t     sequencer state encoding
//   err_t       response status codes (ERR_OK, ERR_RANGE, ERR_OVERLAP, ERR_VIOL)
package sm_ctrl_pkg;

  localparam int ADDR_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_STROBE = 3'd2,
    ST_SETTLE = 3'd3,
    ST_RESP   = 3'd4,
    ST_VRST   = 3'd5
  } state_t;

  typedef logic [1:0] err_t;

  localparam err_t ERR_OK      = 2'd0;
  localparam err_t ERR_RANGE   = 2'd1;
  localparam err_t ERR_OVERLAP = 2'd2;
  localparam err_t ERR_VIOL    = 2'd3;

endpackage

// File: rtl/sm_reset_stretch.sv
// rtl/sm_reset_stretch.sv - violation-driven reset stretcher with reload counter
// Ports:
//   i_clk        clock
//   i_rst_n      asynchronous active-low reset
//   i_viol       violation sample; reloads the stretch counter
//   o_sys_reset  registered stretched reset, high RST_LEN cycles after the last violation
//   o_last       counter is in its final stretch cycle
module sm_reset_stretch #(
  parameter int RST_LEN = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_viol,
  output logic o_sys_reset,
  output logic o_last
);

  localparam int CW = $clog2(RST_LEN + 1);

  logic [CW-1:0] r_cnt;
  logic          r_sys_reset;

  // r_sys_reset tracks "counter will be non-zero next cycle", so the
  // output is registered and drops exactly when the counter empties.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt       <= '0;
      r_sys_reset <= 1'b0;
    end else if (i_viol) begin
      r_cnt       <= CW'(RST_LEN);
      r_sys_reset <= 1'b1;
    end else if (r_cnt != '0) begin
      r_cnt       <= r_cnt - CW'(1);
      r_sys_reset <= (r_cnt != CW'(1));
    end else begin
      r_sys_reset <= 1'b0;
    end
  end

  assign o_sys_reset = r_sys_reset;
  assign o_last      = (r_cnt == CW'(1));

endmodule

// File: rtl/sm_config_ctrl.sv
// rtl/sm_config_ctrl.sv - descriptor sequencer for SPM control with violation reset stretch
// Ports:
//   i_mclk, i_reset_n                    clock, asynchronous active-low reset
//   i_cfg_valid / o_cfg_ready            descriptor request handshake
//   i_cfg_text_start/_end, i_cfg_data_start/_end   ranges (end exclusive)
//   o_rsp_valid / i_rsp_ready, o_rsp_err status response handshake and code
//   o_spm_enable                         one-cycle enable strobe to SPM control
//   o_spm_r12..o_spm_r15                 captured text start/end, data start/end
//   i_spm_violation                      violation from SPM control
//   o_sys_reset                          registered stretched reset request
//   o_viol_count                         saturating count of violation rising edges
module sm_config_ctrl
  import sm_ctrl_pkg::*;
#(
  parameter int RST_LEN = 16,
  parameter int SETTLE  = 2
) (
  input  logic              i_mclk,
  input  logic              i_reset_n,
  input  logic              i_cfg_valid,
  output logic              o_cfg_ready,
  input  logic [ADDR_W-1:0] i_cfg_text_start,
  input  logic [ADDR_W-1:0] i_cfg_text_end,
  input  logic [ADDR_W-1:0] i_cfg_data_start,
  input  logic [ADDR_W-1:0] i_cfg_data_end,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [1:0]        o_rsp_err,
  output logic              o_spm_enable,
  output logic [ADDR_W-1:0] o_spm_r12,
  output logic [ADDR_W-1:0] o_spm_r13,
  output logic [ADDR_W-1:0] o_spm_r14,
  output logic [ADDR_W-1:0] o_spm_r15,
  input  logic              i_spm_violation,
  output logic              o_sys_reset,
  output logic [7:0]        o_viol_count
);

  localparam int SCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_t            r_state;
  logic              r_rsp_valid;
  err_t              r_rsp_err;
  logic              r_spm_enable;
  logic [ADDR_W-1:0] r_r12, r_r13, r_r14, r_r15;
  logic              r_pending;
  logic [SCW-1:0]    r_settle_cnt;
  logic              r_viol_d;
  logic [7:0]        r_viol_count;

  logic w_range_err;
  logic w_overlap;
  logic w_stretch_last;

  sm_reset_stretch #(
    .RST_LEN (RST_LEN)
  ) u_stretch (
    .i_clk       (i_mclk),
    .i_rst_n     (i_reset_n),
    .i_viol      (i_spm_violation),
    .o_sys_reset (o_sys_reset),
    .o_last      (w_stretch_last)
  );

  // Checks run on the captured registers, one cycle after accept.
  assign w_range_err = (r_r12 >= r_r13) || (r_r14 >= r_r15);
  assign w_overlap   = (r_r12 < r_r15) && (r_r14 < r_r13);

  always_ff @(posedge i_mclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= ST_IDLE;
      r_rsp_valid  <= 1'b0;
      r_rsp_err    <= ERR_OK;
      r_spm_enable <= 1'b0;
      r_r12        <= '0;
      r_r13        <= '0;
      r_r14        <= '0;
      r_r15        <= '0;
      r_pending    <= 1'b0;
      r_settle_cnt <= '0;
      r_viol_d     <= 1'b0;
      r_viol_count <= '0;
    end else begin
      r_spm_enable <= 1'b0;
      r_viol_d     <= i_spm_violation;
      if (i_spm_violation && !r_viol_d && (r_viol_count != 8'hFF)) begin
        r_viol_count <= r_viol_count + 8'd1;
      end

      if (i_spm_violation) begin
        r_state     <= ST_VRST;
        r_rsp_valid <= 1'b0;
        case (r_state)
          // cfg_ready was high, so the master saw its descriptor taken;
          // record it and report the violation against it.
          ST_IDLE: begin
            if (i_cfg_valid) begin
              r_r12     <= i_cfg_text_start;
              r_r13     <= i_cfg_text_end;
              r_r14     <= i_cfg_data_start;
              r_r15     <= i_cfg_data_end;
              r_pending <= 1'b1;
              r_rsp_err <= ERR_VIOL;
            end
          end
          ST_CHECK, ST_STROBE, ST_SETTLE: begin
            r_pending <= 1'b1;
            r_rsp_err <= ERR_VIOL;
          end
          // A response consumed on this very edge is not reissued.
          ST_RESP: r_pending <= !i_rsp_ready;
          default: ;
        endcase
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (i_cfg_valid) begin
              r_r12   <= i_cfg_text_start;
              r_r13   <= i_cfg_text_end;
              r_r14   <= i_cfg_data_start;
              r_r15   <= i_cfg_data_end;
              r_state <= ST_CHECK;
            end
          end
          ST_CHECK: begin
            if (w_range_err) begin
              r_rsp_err   <= ERR_RANGE;
              r_rsp_valid <= 1'b1;
              r_state     <= ST_RESP;
            end else if (w_overlap) begin
              r_rsp_err   <= ERR_OVERLAP;
              r_rsp_valid <= 1'b1;
              r_state     <= ST_RESP;
            end else begin
              r_spm_enable <= 1'b1;
              r_state      <= ST_STROBE;
            end
          end
          ST_STROBE: begin
            r_settle_cnt <= SCW'(SETTLE - 1);
            r_state      <= ST_SETTLE;
          end
          ST_SETTLE: begin
            if (r_settle_cnt == '0) begin
              r_rsp_err   <= ERR_OK;
              r_rsp_valid <= 1'b1;
              r_state     <= ST_RESP;
            end else begin
              r_settle_cnt <= r_settle_cnt - SCW'(1);
            end
          end
          ST_RESP: begin
            if (i_rsp_ready) begin
              r_rsp_valid <= 1'b0;
              r_state     <= ST_IDLE;
            end
          end
          ST_VRST: begin
            if (w_stretch_last) begin
              if (r_pending) begin
                r_pending   <= 1'b0;
                r_rsp_valid <= 1'b1;
                r_state     <= ST_RESP;
              end else begin
                r_state <= ST_IDLE;
              end
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign o_cfg_ready  = (r_state == ST_IDLE);
  assign o_rsp_valid  = r_rsp_valid;
  assign o_rsp_err    = r_rsp_err;
  assign o_spm_enable = r_spm_enable;
  assign o_spm_r12    = r_r12;
  assign o_spm_r13    = r_r13;
  assign o_spm_r14    = r_r14;
  assign o_spm_r15    = r_r15;
  assign o_viol_count = r_viol_count;

endmodule

// File: tb/tb_sm_config_ctrl.sv
// tb/tb_sm_config_ctrl.sv - self-checking bench for sm_config_ctrl
module tb_sm_config_ctrl;

  localparam int RST_LEN = 16;
  localparam int SETTLE  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [15:0] ts = '0, te = '0, ds = '0, de = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [1:0]  rsp_err;
  logic        spm_enable;
  logic [15:0] r12, r13, r14, r15;
  logic        viol = 1'b0;
  logic        sys_reset;
  logic [7:0]  viol_count;

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  sm_config_ctrl #(.RST_LEN(RST_LEN), .SETTLE(SETTLE)) dut (
    .i_mclk           (clk),
    .i_reset_n        (rst_n),
    .i_cfg_valid      (cfg_valid),
    .o_cfg_ready      (cfg_ready),
    .i_cfg_text_start (ts),
    .i_cfg_text_end   (te),
    .i_cfg_data_start (ds),
    .i_cfg_data_end   (de),
    .o_rsp_valid      (rsp_valid),
    .i_rsp_ready      (rsp_ready),
    .o_rsp_err        (rsp_err),
    .o_spm_enable     (spm_enable),
    .o_spm_r12        (r12),
    .o_spm_r13        (r13),
    .o_spm_r14        (r14),
    .o_spm_r15        (r15),
    .i_spm_violation  (viol),
    .o_sys_reset      (sys_reset),
    .o_viol_count     (viol_count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference for the violation side: reset is high while the last high
  // violation sample is fewer than RST_LEN edges old; count = rising edges.
  int  m_edge = 0;
  int  m_last = 0;
  bit  m_have = 1'b0;
  bit  m_prev = 1'b0;
  int  m_count = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_have  = 1'b0;
      m_prev  = 1'b0;
      m_count = 0;
    end else begin
      m_edge++;
      if (viol) begin
        m_last = m_edge;
        m_have = 1'b1;
        if (!m_prev) m_count = (m_count >= 255) ? 255 : m_count + 1;
      end
      m_prev = viol;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("mon_sys_reset", sys_reset, (m_have && (m_edge - m_last) < RST_LEN) ? 1 : 0);
      chk("mon_viol_count", viol_count, m_count);
    end
  end

  function automatic logic [1:0] model_err(input int a0, input int a1, input int b0, input int b1);
    int lo, hi;
    if (a1 - a0 <= 0 || b1 - b0 <= 0) return 2'd1;
    lo = (a0 > b0) ? a0 : b0;
    hi = (a1 < b1) ? a1 : b1;
    if (lo < hi) return 2'd2;
    return 2'd0;
  endfunction

  // One descriptor transaction; cycle n+1 is observed at iteration n.
  task automatic do_cfg(input logic [15:0] a0, a1, b0, b1, input logic [1:0] exp_err, input int hold);
    int n, first, en_cnt, en_at;
    chk("cfg_ready_idle", cfg_ready, 1);
    ts = a0; te = a1; ds = b0; de = b1;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    chk("cfg_ready_busy", cfg_ready, 0);
    chk("spm_regs", {r12, r13, r14, r15}, {a0, a1, b0, b1});
    n = 0; first = -1; en_cnt = 0; en_at = -1;
    while (first < 0 && n < 40) begin
      if (spm_enable) begin en_cnt++; en_at = n; end
      if (rsp_valid) first = n;
      else begin tick(); n++; end
    end
    chk("rsp_latency", first, (exp_err == 2'd0) ? SETTLE + 2 : 1);
    chk("enable_pulses", en_cnt, (exp_err == 2'd0) ? 1 : 0);
    if (exp_err == 2'd0) chk("enable_cycle", en_at, 1);
    chk("rsp_err", rsp_err, exp_err);
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("rsp_hold", {rsp_valid, rsp_err}, {1'b1, exp_err});
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("rsp_done", {rsp_valid, cfg_ready}, 2'b01);
  endtask

  typedef struct {
    logic [15:0] a0, a1, b0, b1;
    logic [1:0]  err;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int hi, t, last_hi;
    bit seen;
    logic [7:0] base;
    logic [15:0] a0, a1, b0, b1;

    vecs[0] = '{16'hA000, 16'hA400, 16'h0500, 16'h0C00, 2'd0};
    vecs[1] = '{16'hA400, 16'hA000, 16'h0500, 16'h0C00, 2'd1};
    vecs[2] = '{16'hA000, 16'hA400, 16'hA200, 16'hA600, 2'd2};
    vecs[3] = '{16'h1000, 16'h1000, 16'h2000, 16'h3000, 2'd1};
    vecs[4] = '{16'h1000, 16'h2000, 16'h3000, 16'h3000, 2'd1};
    vecs[5] = '{16'h1000, 16'h2000, 16'h2000, 16'h3000, 2'd0};
    vecs[6] = '{16'h2000, 16'h3000, 16'h1000, 16'h2000, 2'd0};
    vecs[7] = '{16'h2000, 16'h3000, 16'h1000, 16'h2001, 2'd2};
    vecs[8] = '{16'h0000, 16'hFFFF, 16'h1000, 16'h1001, 2'd2};
    vecs[9] = '{16'h8000, 16'h8001, 16'h7FFF, 16'h8000, 2'd0};

    repeat (3) @(negedge clk);
    chk("reset_ctrl", {cfg_ready, rsp_valid, rsp_err, spm_enable, sys_reset, viol_count}, {1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 8'd0});
    chk("reset_regs", {r12, r13, r14, r15}, 64'd0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    tick();

    for (int i = 0; i < 10; i++)
      do_cfg(vecs[i].a0, vecs[i].a1, vecs[i].b0, vecs[i].b1, vecs[i].err, i % 3);
    chk("regs_hold", {r12, r13, r14, r15}, {vecs[9].a0, vecs[9].a1, vecs[9].b0, vecs[9].b1});

    for (int i = 0; i < 40; i++) begin
      a0 = 16'($urandom_range(0, 15)) << 12;
      a1 = 16'($urandom_range(0, 15)) << 12;
      b0 = 16'($urandom_range(0, 15)) << 12;
      b1 = 16'($urandom_range(0, 15)) << 12;
      do_cfg(a0, a1, b0, b1, model_err(int'(a0), int'(a1), int'(b0), int'(b1)), $urandom_range(0, 3));
    end

    // Violation for one cycle during SETTLE.
    base = viol_count;
    ts = 16'hA000; te = 16'hA400; ds = 16'h0500; de = 16'h0C00;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    tick();
    chk("A_strobe", spm_enable, 1);
    tick();
    viol = 1'b1;
    tick();
    viol = 1'b0;
    hi = 0; t = 0; seen = 1'b0;
    while (!rsp_valid && t < 60) begin
      if (sys_reset) hi++;
      if (cfg_ready) seen = 1'b1;
      tick(); t++;
    end
    chk("A_stretch_len", hi, RST_LEN);
    chk("A_cfg_ready_vrst", seen, 0);
    chk("A_rsp", {rsp_valid, rsp_err}, {1'b1, 2'd3});
    chk("A_viol_count", viol_count, base + 8'd1);
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    chk("A_done", {rsp_valid, cfg_ready}, 2'b01);

    // 5-cycle violation, then a second pulse 3 cycles later.
    base = viol_count;
    hi = 0; last_hi = -1;
    for (int k = 0; k < 40; k++) begin
      viol = (k < 5 || k == 8);
      tick();
      if (sys_reset) begin hi++; last_hi = k; end
    end
    viol = 1'b0;
    chk("B_high_cycles", hi, 9 + RST_LEN - 1);
    chk("B_last_high", last_hi, 8 + RST_LEN - 1);
    chk("B_viol_count", viol_count, base + 8'd2);
    chk("B_idle", {cfg_ready, rsp_valid}, 2'b10);

    // Violation while a response waits on rsp_ready.
    ts = 16'hA400; te = 16'hA000; ds = 16'h0500; de = 16'h0C00;
    cfg_valid = 1'b1; tick(); cfg_valid = 1'b0;
    t = 0;
    while (!rsp_valid && t < 20) begin tick(); t++; end
    chk("C_rsp_first", {rsp_valid, rsp_err}, {1'b1, 2'd1});
    repeat (3) tick();
    viol = 1'b1; tick(); viol = 1'b0;
    hi = 0; t = 0; seen = 1'b0;
    while (!rsp_valid && t < 60) begin
      if (sys_reset) hi++;
      if (cfg_ready) seen = 1'b1;
      tick(); t++;
    end
    chk("C_stretch_len", hi, RST_LEN);
    chk("C_cfg_ready_vrst", seen, 0);
    chk("C_rsp_again", {rsp_valid, rsp_err}, {1'b1, 2'd1});
    seen = 1'b0;
    repeat (5) begin tick(); if (cfg_ready || !rsp_valid) seen = 1'b1; end
    chk("C_hold", seen, 0);
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    chk("C_done", {rsp_valid, cfg_ready}, 2'b01);

    // Random violation stream while idle.
    for (int k = 0; k < 200; k++) begin
      viol = ($urandom_range(0, 5) == 0);
      tick();
    end
    viol = 1'b0;
    t = 0;
    while (!(cfg_ready && !sys_reset) && t < 40) begin tick(); t++; end
    chk("R_idle", {cfg_ready, sys_reset, rsp_valid}, 3'b100);

    // Saturation.
    repeat (300) begin viol = 1'b1; tick(); viol = 1'b0; tick(); end
    chk("S_saturate", viol_count, 8'd255);
    repeat (RST_LEN + 2) tick();
    chk("S_idle", {cfg_ready, sys_reset}, 2'b10);

    // Asynchronous reset during STROBE.
    ts = 16'h1000; te = 16'h2000; ds = 16'h3000; de = 16'h4000;
    cfg_valid = 1'b1; tick(); cfg_valid = 1'b0;
    tick();
    chk("D1_strobe", spm_enable, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("D1_ctrl", {cfg_ready, rsp_valid, rsp_err, spm_enable, sys_reset, viol_count}, {1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 8'd0});
    chk("D1_regs", {r12, r13, r14, r15}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin tick(); if (rsp_valid || spm_enable) seen = 1'b1; end
    chk("D1_no_rsp", seen, 0);

    // Asynchronous reset during VRST with a pending response.
    cfg_valid = 1'b1; tick(); cfg_valid = 1'b0;
    viol = 1'b1; tick(); viol = 1'b0;
    seen = 1'b0;
    repeat (4) begin tick(); if (spm_enable) seen = 1'b1; end
    chk("D2_no_strobe", seen, 0);
    chk("D2_vrst", {sys_reset, cfg_ready}, 2'b10);
    #2 rst_n = 1'b0;
    #1;
    chk("D2_ctrl", {cfg_ready, rsp_valid, rsp_err, spm_enable, sys_reset, viol_count}, {1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 8'd0});
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (RST_LEN + 10) begin tick(); if (rsp_valid || sys_reset || !cfg_ready) seen = 1'b1; end
    chk("D2_no_rsp", seen, 0);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
